// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and helpers for the forwarding / hazard controller.
// Optional statistics counters are enabled with FORW_STATS_EN.
package fwd_hazard_ctrl_pkg;

    // src_match takes indices zero-extended to this width.
    localparam int unsigned MAX_REG_W = 8;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } haz_state_t;

    // ID-side source hits against the EX and MEM destinations
    typedef struct packed {
        logic ex_a;
        logic ex_b;
        logic mem_a;
        logic mem_b;
    } src_hit_t;

    function automatic logic src_match(
        input logic [MAX_REG_W-1:0] rs,
        input logic [MAX_REG_W-1:0] rd,
        input logic                 regwrite
    );
        return regwrite && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_mux3.sv
// Select-driven 3:1 operand mux; the unused 2'b11 code falls back to the register value.
module fwd_mux3
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      i_sel,
    input  logic [XLEN-1:0] i_reg,
    input  logic [XLEN-1:0] i_exmem,
    input  logic [XLEN-1:0] i_memwb,
    output logic [XLEN-1:0] o_y
);

    always_comb begin
        o_y = i_reg;
        case (i_sel)
            FWD_EXMEM: o_y = i_exmem;
            FWD_MEMWB: o_y = i_memwb;
            default:   o_y = i_reg;
        endcase
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Registered forwarding-select generator, EX operand muxes and load-use/no-forwarding stall FSM.
// Define FORW_STATS_EN to add the fwd_cnt / stall_cnt statistics outputs.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MAX_STALL  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  isForw_ON,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regwrite,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic [XLEN-1:0]       memwb_result,
    input  logic [XLEN-1:0]       data1,
    input  logic [XLEN-1:0]       data2,
    input  logic [XLEN-1:0]       s_data,
    output logic                  stall,
    output logic                  bubble,
    output logic [1:0]            forwA,
    output logic [1:0]            forwB,
    output logic [XLEN-1:0]       operand1,
    output logic [XLEN-1:0]       operand2,
    output logic [XLEN-1:0]       sData,
    output logic                  hazard_err
`ifdef FORW_STATS_EN
    ,
    output logic [31:0]           fwd_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);

    src_hit_t   w_hit;
    logic       w_ex_hit;
    logic       w_mem_hit;
    logic       w_hazard;
    haz_state_t r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic       r_err, w_err_nxt;
    fwd_sel_t   r_forwA, r_forwB, w_fA_nxt, w_fB_nxt;

    assign w_hit.ex_a  = src_match(MAX_REG_W'(id_rs1), MAX_REG_W'(ex_rd), ex_regwrite);
    assign w_hit.ex_b  = id_use_rs2 && src_match(MAX_REG_W'(id_rs2), MAX_REG_W'(ex_rd), ex_regwrite);
    assign w_hit.mem_a = src_match(MAX_REG_W'(id_rs1), MAX_REG_W'(mem_rd), mem_regwrite);
    assign w_hit.mem_b = id_use_rs2 && src_match(MAX_REG_W'(id_rs2), MAX_REG_W'(mem_rd), mem_regwrite);

    assign w_ex_hit  = w_hit.ex_a || w_hit.ex_b;
    assign w_mem_hit = w_hit.mem_a || w_hit.mem_b;

    // WB never stalls: the register file writes before it is read.
    assign w_hazard = id_valid && (isForw_ON ? (ex_memread && w_ex_hit)
                                             : (w_ex_hit || w_mem_hit));

    assign stall      = w_hazard && rst_n;
    assign bubble     = w_hazard && rst_n;
    assign hazard_err = r_err;
    assign forwA      = r_forwA;
    assign forwB      = r_forwB;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        case (r_state)
            RUN: begin
                w_cnt_nxt = '0;
                if (w_hazard) begin
                    w_state_nxt = STALL;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            STALL: begin
                if (!w_hazard) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(MAX_STALL)) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A bubble carries no sources, so a stalling edge loads REG selects.
    always_comb begin
        w_fA_nxt = FWD_REG;
        w_fB_nxt = FWD_REG;
        if (isForw_ON && !w_hazard) begin
            if (w_hit.ex_a)       w_fA_nxt = FWD_EXMEM;
            else if (w_hit.mem_a) w_fA_nxt = FWD_MEMWB;
            if (w_hit.ex_b)       w_fB_nxt = FWD_EXMEM;
            else if (w_hit.mem_b) w_fB_nxt = FWD_MEMWB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_forwA <= FWD_REG;
            r_forwB <= FWD_REG;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_forwA <= w_fA_nxt;
            r_forwB <= w_fB_nxt;
        end
    end

`ifdef FORW_STATS_EN
    logic [31:0] r_fwd_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_fwd_cnt <= r_fwd_cnt + 32'(w_fA_nxt != FWD_REG) + 32'(w_fB_nxt != FWD_REG);
            if (w_hazard) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fwd_cnt   = r_fwd_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

    fwd_mux3 #(.XLEN(XLEN)) u_mux_op1 (
        .i_sel   (r_forwA),
        .i_reg   (data1),
        .i_exmem (exmem_result),
        .i_memwb (memwb_result),
        .o_y     (operand1)
    );

    fwd_mux3 #(.XLEN(XLEN)) u_mux_op2 (
        .i_sel   (r_forwB),
        .i_reg   (data2),
        .i_exmem (exmem_result),
        .i_memwb (memwb_result),
        .o_y     (operand2)
    );

    fwd_mux3 #(.XLEN(XLEN)) u_mux_sdata (
        .i_sel   (r_forwB),
        .i_reg   (s_data),
        .i_exmem (exmem_result),
        .i_memwb (memwb_result),
        .o_y     (sData)
    );

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed and model-checked random bench for fwd_hazard_ctrl.
module tb_fwd_hazard_ctrl;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int MS   = 3;

    logic            clk;
    logic            rst_n;
    logic            isForw_ON;
    logic            id_valid;
    logic [RW-1:0]   id_rs1, id_rs2;
    logic            id_use_rs2;
    logic [RW-1:0]   ex_rd;
    logic            ex_regwrite, ex_memread;
    logic [RW-1:0]   mem_rd;
    logic            mem_regwrite;
    logic [XLEN-1:0] exmem_result, memwb_result, data1, data2, s_data;
    logic            stall, bubble;
    logic [1:0]      forwA, forwB;
    logic [XLEN-1:0] operand1, operand2, sData;
    logic            hazard_err;
`ifdef FORW_STATS_EN
    logic [31:0]     fwd_cnt, stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fwd_hazard_ctrl #(.XLEN(XLEN), .REG_ADDR_W(RW), .MAX_STALL(MS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .isForw_ON    (isForw_ON),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .exmem_result (exmem_result),
        .memwb_result (memwb_result),
        .data1        (data1),
        .data2        (data2),
        .s_data       (s_data),
        .stall        (stall),
        .bubble       (bubble),
        .forwA        (forwA),
        .forwB        (forwB),
        .operand1     (operand1),
        .operand2     (operand2),
        .sData        (sData),
        .hazard_err   (hazard_err)
`ifdef FORW_STATS_EN
        ,
        .fwd_cnt      (fwd_cnt),
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_rs1       = '0;
        id_rs2       = '0;
        id_use_rs2   = 1'b0;
        ex_rd        = '0;
        ex_regwrite  = 1'b0;
        ex_memread   = 1'b0;
        mem_rd       = '0;
        mem_regwrite = 1'b0;
    endtask

    function automatic logic [31:0] pick(input int s, input logic [31:0] r,
                                         input logic [31:0] e, input logic [31:0] m);
        if (s == 1) return e;
        if (s == 2) return m;
        return r;
    endfunction

    // reference-model state for the random run
    int m_fA, m_fB, m_run, nA, nB;
    logic m_err;
    int m_fwd, m_stl;
    int pass_fA [3];
    int pass_fB [3];
    logic eA, eB, mA, mB, hz;

    initial begin
        rst_n        = 1'b0;
        isForw_ON    = 1'b0;
        data1        = 32'h1111_1111;
        data2        = 32'h2222_2222;
        s_data       = 32'h3333_3333;
        exmem_result = 32'hAAAA_AAAA;
        memwb_result = 32'hBBBB_BBBB;
        idle();
        // hazard-looking inputs held during reset must not stall
        id_valid = 1'b1; ex_rd = 5'd2; ex_regwrite = 1'b1; id_rs1 = 5'd2;
        tick(); tick();
        chk("rst_stall",  stall, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_err",    hazard_err, 0);
        chk("rst_forwA",  forwA, 0);
        chk("rst_forwB",  forwB, 0);
`ifdef FORW_STATS_EN
        chk("rst_fwd_cnt",   fwd_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        idle();
        rst_n = 1'b1;
        tick();

        // 1: ALU result forwarded from EX/MEM
        isForw_ON = 1'b1; id_valid = 1'b1; ex_rd = 5'd5; ex_regwrite = 1'b1; id_rs1 = 5'd5;
        #1;
        chk("t1_stall", stall, 0);
        tick();
        chk("t1_forwA",    forwA, 1);
        chk("t1_operand1", operand1, 32'hAAAA_AAAA);
        chk("t1_forwB",    forwB, 0);
        chk("t1_operand2", operand2, 32'h2222_2222);

        // 2: load-use on rs2
        idle();
        id_valid = 1'b1; ex_rd = 5'd7; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        chk("t2_stall",  stall, 1);
        chk("t2_bubble", bubble, 1);
        tick();
        chk("t2_forwB_bubble", forwB, 0);
        ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd7; mem_regwrite = 1'b1;
        #1;
        chk("t2_stall_clear", stall, 0);
        tick();
        chk("t2_forwB", forwB, 2);
        chk("t2_sData", sData, 32'hBBBB_BBBB);
        chk("t2_op2",   operand2, 32'hBBBB_BBBB);

        // 3: forwarding off stalls through EX and MEM
        idle();
        isForw_ON = 1'b0; id_valid = 1'b1; ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs1 = 5'd3;
        #1;
        chk("t3_stall_ex", stall, 1);
        tick();
        ex_rd = '0; ex_regwrite = 1'b0; mem_rd = 5'd3; mem_regwrite = 1'b1;
        #1;
        chk("t3_stall_mem", stall, 1);
        tick();
        chk("t3_forwA_stall", forwA, 0);
        mem_rd = '0; mem_regwrite = 1'b0;
        #1;
        chk("t3_stall_done", stall, 0);
        tick();
        chk("t3_forwA", forwA, 0);
        chk("t3_err",   hazard_err, 0);

        // 4: x0 never matches; EX beats MEM
        idle();
        isForw_ON = 1'b1; id_valid = 1'b1; ex_rd = '0; ex_regwrite = 1'b1; id_rs1 = '0;
        #1;
        chk("t4_x0_stall", stall, 0);
        tick();
        chk("t4_x0_forwA", forwA, 0);
        chk("t4_x0_op1",   operand1, 32'h1111_1111);
        ex_rd = 5'd9; mem_rd = 5'd9; mem_regwrite = 1'b1; id_rs1 = 5'd9;
        #1;
        chk("t4_prio_stall", stall, 0);
        tick();
        chk("t4_prio_forwA", forwA, 1);
        chk("t4_prio_op1",   operand1, 32'hAAAA_AAAA);

        // 5: stall limit, reset mid-stall, mode toggle mid-stall
        idle();
        isForw_ON = 1'b0; id_valid = 1'b1; ex_rd = 5'd4; ex_regwrite = 1'b1; id_rs1 = 5'd4;
        #1;
        chk("t5_stall", stall, 1);
        chk("t5_err0",  hazard_err, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("t5_err_c%0d", i), hazard_err, 0);
        end
        tick();
        chk("t5_err_set",   hazard_err, 1);
        chk("t5_stall_on",  stall, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_stall",  stall, 0);
        chk("t5_rst_bubble", bubble, 0);
        chk("t5_rst_err",    hazard_err, 0);
        rst_n = 1'b1;
        #1;
        chk("t5_restart_stall", stall, 1);
        tick();
        chk("t5_restart_err", hazard_err, 0);
        isForw_ON = 1'b1;
        #1;
        chk("t5_toggle_stall", stall, 0);
        tick();
        chk("t5_toggle_forwA", forwA, 1);

        // 6: random run against the reference model
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        m_fA = 0; m_fB = 0; m_run = 0; m_err = 1'b0; m_fwd = 0; m_stl = 0;
        for (int k = 0; k < 3; k++) begin
            pass_fA[k] = 0;
            pass_fB[k] = 0;
        end
        for (int v = 0; v < 100; v++) begin
            isForw_ON    = ($urandom_range(0, 3) != 0);
            id_valid     = ($urandom_range(0, 7) != 0);
            id_rs1       = RW'($urandom_range(0, 3));
            id_rs2       = RW'($urandom_range(0, 3));
            id_use_rs2   = 1'($urandom_range(0, 1));
            ex_rd        = RW'($urandom_range(0, 3));
            ex_regwrite  = ($urandom_range(0, 3) != 0);
            ex_memread   = ($urandom_range(0, 3) == 0);
            mem_rd       = RW'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            exmem_result = $urandom;
            memwb_result = $urandom;
            data1        = $urandom;
            data2        = $urandom;
            s_data       = $urandom;
            #1;
            eA = ex_regwrite && (ex_rd != 0) && (ex_rd == id_rs1);
            eB = id_use_rs2 && ex_regwrite && (ex_rd != 0) && (ex_rd == id_rs2);
            mA = mem_regwrite && (mem_rd != 0) && (mem_rd == id_rs1);
            mB = id_use_rs2 && mem_regwrite && (mem_rd != 0) && (mem_rd == id_rs2);
            if (!id_valid)      hz = 1'b0;
            else if (isForw_ON) hz = ex_memread && (eA || eB);
            else                hz = eA || eB || mA || mB;

            chk($sformatf("rnd%0d_stall", v),  stall, hz);
            chk($sformatf("rnd%0d_bubble", v), bubble, hz);
            chk($sformatf("rnd%0d_forwA", v),  forwA, m_fA);
            chk($sformatf("rnd%0d_forwB", v),  forwB, m_fB);
            chk($sformatf("rnd%0d_op1", v),    operand1, pick(m_fA, data1, exmem_result, memwb_result));
            chk($sformatf("rnd%0d_op2", v),    operand2, pick(m_fB, data2, exmem_result, memwb_result));
            chk($sformatf("rnd%0d_sdata", v),  sData, pick(m_fB, s_data, exmem_result, memwb_result));
            chk($sformatf("rnd%0d_err", v),    hazard_err, m_err);
            if (forwA < 2'd3) pass_fA[forwA]++;
            if (forwB < 2'd3) pass_fB[forwB]++;

            if (hz && m_run >= MS) m_err = 1'b1;
            m_run = hz ? m_run + 1 : 0;
            if (hz) m_stl++;
            if (!isForw_ON || hz) begin
                nA = 0;
                nB = 0;
            end else begin
                nA = eA ? 1 : (mA ? 2 : 0);
                nB = eB ? 1 : (mB ? 2 : 0);
            end
            if (nA != 0) m_fwd++;
            if (nB != 0) m_fwd++;
            m_fA = nA;
            m_fB = nB;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("cov_fA%0d", k), (pass_fA[k] > 0), 1);
            chk($sformatf("cov_fB%0d", k), (pass_fB[k] > 0), 1);
        end
`ifdef FORW_STATS_EN
        chk("rnd_fwd_cnt",   fwd_cnt, m_fwd);
        chk("rnd_stall_cnt", stall_cnt, m_stl);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
